// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory stage: access FSM states, operation kinds
// and the address field layout used by the controller and its RAM.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    typedef enum logic {
        MEM_RD,
        MEM_WR
    } mem_op_t;

    localparam int BYTE_OFFSET_BITS = 2;

    function automatic int index_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/data_ram.sv
// Synchronous single-port word RAM; read data is registered on the same edge
// as the read request and is the only part of the block that resets.
import data_mem_ctrl_pkg::*;

module data_ram #(
    parameter int mbus  = 32,
    parameter int DEPTH = 64,
    localparam int IW   = index_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            re,
    input  logic [IW-1:0]   index,
    input  logic [mbus-1:0] wdata,
    output logic [mbus-1:0] rdata
);

    logic [mbus-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: fixed-latency access FSM around data_ram, stalling the
// core while an access is in flight and flagging illegal addresses.
import data_mem_ctrl_pkg::*;

module data_mem_ctrl #(
    parameter int mbus        = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MWE,
    input  logic            MRE,
    input  logic [mbus-1:0] addressData,
    input  logic [mbus-1:0] storeData,
    output logic [mbus-1:0] loadedData,
    output logic            stall,
    output logic            addrFault
);

    localparam int IW = index_width(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    mem_state_t      state, nextState;
    mem_op_t         opReg, curOp, commitOp;
    logic [IW-1:0]   idxReg, curIdx, commitIdx;
    logic [mbus-1:0] dataReg, commitData;
    logic [CW-1:0]   count;
    logic            request, legal, enterDone, ramWe, ramRe;

    // Only a single, aligned, in-range request may touch the RAM.
    assign request = MWE | MRE;
    assign legal   = (MWE ^ MRE)
                   && (addressData[BYTE_OFFSET_BITS-1:0] == '0)
                   && ((addressData >> (IW + BYTE_OFFSET_BITS)) == '0);
    assign curOp   = MWE ? MEM_WR : MEM_RD;
    assign curIdx  = addressData[IW+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (legal) nextState = (WAIT_CYCLES == 0) ? DONE : ACCESS;
            ACCESS:  if (count == '0) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // With no wait cycles the commit happens on the accepting edge, before
    // the latches hold anything, so the live inputs are used there instead.
    always_comb begin
        stall      = (state == ACCESS) || (state == IDLE && legal);
        enterDone  = (state != DONE) && (nextState == DONE);
        commitOp   = (state == IDLE) ? curOp : opReg;
        commitIdx  = (state == IDLE) ? curIdx : idxReg;
        commitData = (state == IDLE) ? storeData : dataReg;
        ramWe      = enterDone && rst && (commitOp == MEM_WR);
        ramRe      = enterDone && (commitOp == MEM_RD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= '0;
            opReg     <= MEM_RD;
            idxReg    <= '0;
            dataReg   <= '0;
            addrFault <= 1'b0;
        end else begin
            if (state == IDLE && legal) begin
                opReg   <= curOp;
                idxReg  <= curIdx;
                dataReg <= storeData;
                count   <= (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
            end else if (state == ACCESS && count != '0) begin
                count <= count - 1'b1;
            end
            if (state == IDLE && request && !legal) begin
                addrFault <= 1'b1;
            end
        end
    end

    data_ram #(
        .mbus  (mbus),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ramWe),
        .re    (ramRe),
        .index (commitIdx),
        .wdata (commitData),
        .rdata (loadedData)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a WAIT_CYCLES=2 instance for the main
// sequence and a WAIT_CYCLES=0 instance for the single-cycle access path.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        MWE, MRE;
    logic [31:0] addressData, storeData;
    logic [31:0] loadedData;
    logic        stall, addrFault;

    logic        bMWE, bMRE;
    logic [31:0] bAddr, bData;
    logic [31:0] bLoaded;
    logic        bStall, bFault;

    int checks   = 0;
    int failures = 0;

    data_mem_ctrl #(.mbus(32), .DEPTH(64), .WAIT_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .MWE         (MWE),
        .MRE         (MRE),
        .addressData (addressData),
        .storeData   (storeData),
        .loadedData  (loadedData),
        .stall       (stall),
        .addrFault   (addrFault)
    );

    data_mem_ctrl #(.mbus(32), .DEPTH(64), .WAIT_CYCLES(0)) dutZero (
        .clk         (clk),
        .rst         (rst),
        .MWE         (bMWE),
        .MRE         (bMRE),
        .addressData (bAddr),
        .storeData   (bData),
        .loadedData  (bLoaded),
        .stall       (bStall),
        .addrFault   (bFault)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Holds a request on the WAIT_CYCLES=2 instance until stall drops, checking
    // stall each cycle and optionally loadedData in the DONE cycle.
    task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a,
                                 input logic [31:0] d, input logic chkLd,
                                 input logic [31:0] expLd, input string tag);
        MWE = w; MRE = r; addressData = a; storeData = d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput({tag, "_stall_hi"}, {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput({tag, "_stall_lo"}, {31'd0, stall}, 32'd0);
        if (chkLd) checkOutput({tag, "_data"}, loadedData, expLd);
        @(posedge clk); #1;
        MWE = 1'b0; MRE = 1'b0; addressData = '0; storeData = '0;
    endtask

    // A rejected request is offered for one cycle; stall must stay low.
    task automatic applyIllegal(input logic w, input logic r, input logic [31:0] a,
                                input logic [31:0] expLd, input string tag);
        MWE = w; MRE = r; addressData = a; storeData = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        MWE = 1'b0; MRE = 1'b0; addressData = '0; storeData = '0;
        @(negedge clk);
        checkOutput({tag, "_fault"}, {31'd0, addrFault}, 32'd1);
        checkOutput({tag, "_stall2"}, {31'd0, stall}, 32'd0);
        checkOutput({tag, "_ld"}, loadedData, expLd);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        MWE = 1'b0; MRE = 1'b0; addressData = '0; storeData = '0;
        bMWE = 1'b0; bMRE = 1'b0; bAddr = '0; bData = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_ld", loadedData, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_fault", {31'd0, addrFault}, 32'd0);
        @(posedge clk); #1;

        applyStimulus(1'b1, 1'b0, 32'h8, 32'h3F, 1'b1, 32'h0, "wr8");
        applyStimulus(1'b0, 1'b1, 32'h8, 32'h0, 1'b1, 32'h3F, "rd8");

        applyStimulus(1'b1, 1'b0, 32'h4, 32'h9, 1'b1, 32'h3F, "wr4");
        applyStimulus(1'b0, 1'b1, 32'h8, 32'h0, 1'b1, 32'h3F, "rd8b");
        applyStimulus(1'b0, 1'b1, 32'h4, 32'h0, 1'b1, 32'h9, "rd4");
        applyStimulus(1'b1, 1'b0, 32'hC, 32'h77, 1'b1, 32'h9, "wrC");
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h55, 1'b0, 32'h0, "wr0");
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, "wr10");
        @(negedge clk);
        checkOutput("pre_fault", {31'd0, addrFault}, 32'd0);
        @(posedge clk); #1;

        applyIllegal(1'b0, 1'b1, 32'h6, 32'h9, "misalign");
        applyIllegal(1'b1, 1'b0, 32'h100, 32'h9, "range");
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h55, "rd0");
        applyIllegal(1'b1, 1'b1, 32'h8, 32'h55, "both");
        applyStimulus(1'b0, 1'b1, 32'h8, 32'h0, 1'b1, 32'h3F, "rd8c");

        MWE = 1'b1; addressData = 32'h10; storeData = 32'hFF;
        @(negedge clk);
        checkOutput("midwr_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; MWE = 1'b0; addressData = '0; storeData = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midwr_stall_after", {31'd0, stall}, 32'd0);
        checkOutput("midwr_fault_clr", {31'd0, addrFault}, 32'd0);
        checkOutput("midwr_ld_clr", loadedData, 32'd0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0, "rd10");
        applyStimulus(1'b0, 1'b1, 32'h8, 32'h0, 1'b1, 32'h3F, "rd8_kept");

        bMWE = 1'b1; bAddr = 32'h8; bData = 32'h3F;
        @(negedge clk);
        checkOutput("z_wr8_stall", {31'd0, bStall}, 32'd1);
        @(posedge clk); #1;
        bAddr = 32'h4; bData = 32'h9;
        @(negedge clk);
        checkOutput("z_done1", {31'd0, bStall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("z_wr4_stall", {31'd0, bStall}, 32'd1);
        @(posedge clk); #1;
        bMWE = 1'b0; bMRE = 1'b1; bAddr = 32'h8; bData = '0;
        @(negedge clk);
        checkOutput("z_done2", {31'd0, bStall}, 32'd0);
        checkOutput("z_ld_wr", bLoaded, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("z_rd8_stall", {31'd0, bStall}, 32'd1);
        @(posedge clk); #1;
        bAddr = 32'h4;
        @(negedge clk);
        checkOutput("z_rd8_done", {31'd0, bStall}, 32'd0);
        checkOutput("z_rd8_data", bLoaded, 32'h3F);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("z_rd4_stall", {31'd0, bStall}, 32'd1);
        @(posedge clk); #1;
        bMRE = 1'b0; bAddr = '0;
        @(negedge clk);
        checkOutput("z_rd4_done", {31'd0, bStall}, 32'd0);
        checkOutput("z_rd4_data", bLoaded, 32'h9);
        checkOutput("z_fault", {31'd0, bFault}, 32'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
